// File: rtl/mul_share_arbiter_if.sv
// Requester-side and multiplier-side signals of the shared multiplier arbiter.
// The arbiter uses the slave view; whoever drives the requesters and the multiplier uses the master view.
interface mul_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 3,
  parameter int A_W     = 10,
  parameter int B_W     = 11,
  parameter int P_W     = 20
);
  localparam int INF_W = $clog2(MUL_LAT + 1);

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [NUM_REQ-1:0]     rsp_ready;
  logic [P_W-1:0]         rsp_data;
  logic                   mul_ce;
  logic [A_W-1:0]         mul_din0;
  logic [B_W-1:0]         mul_din1;
  logic [P_W-1:0]         mul_dout;
  logic [INF_W-1:0]       inflight;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_dout,
    output req_ready, rsp_valid, rsp_data, mul_ce, mul_din0, mul_din1, inflight
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_dout,
    input  req_ready, rsp_valid, rsp_data, mul_ce, mul_din0, mul_din1, inflight
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NUM_REQ requesters, with a
// {valid,id} tag pipe that freezes together with the multiplier under response backpressure.
module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 3,
  parameter int A_W     = 10,
  parameter int B_W     = 11,
  parameter int P_W     = 20
) (
  input  logic              clk,
  input  logic              reset,
  mul_share_arbiter_if.slave bus_io
);
  localparam int INF_W = $clog2(MUL_LAT + 1);
  localparam int LAST  = MUL_LAT - 1;

  logic [MUL_LAT-1:0] tag_v_q, tag_v_d;
  logic [ID_W-1:0]    tag_id_q [MUL_LAT];
  logic [ID_W-1:0]    tag_id_d [MUL_LAT];
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [INF_W-1:0]   inflight_q, inflight_d;

  logic               stall_s;
  logic               ce_s;
  logic               arb_en_s;
  logic               retire_s;
  logic               grant_any_s;
  logic [ID_W-1:0]    grant_id_s;
  logic [ID_W-1:0]    head_id_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic [NUM_REQ-1:0] rsp_valid_s;
  logic [A_W-1:0]     din0_s;
  logic [B_W-1:0]     din1_s;
  logic [P_W-1:0]     rsp_data_s;

  assign head_id_s  = tag_id_q[LAST];
  assign stall_s    = tag_v_q[LAST] & ~bus_io.rsp_ready[head_id_s];
  assign ce_s       = ~stall_s;
  assign retire_s   = tag_v_q[LAST] & ~stall_s;
  // Reset gates the grant so req_ready drops the moment reset is asserted.
  assign arb_en_s   = reset & ~stall_s;
  assign rsp_data_s = bus_io.mul_dout;

  // Round-robin search: first asserted req_valid at or above rr_ptr, wrapping.
  always_comb begin
    logic [ID_W:0] sum_v;
    logic [ID_W:0] idx_v;
    grant_any_s = 1'b0;
    grant_id_s  = '0;
    sum_v       = '0;
    idx_v       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_v = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      idx_v = (sum_v >= (ID_W+1)'(NUM_REQ)) ? (sum_v - (ID_W+1)'(NUM_REQ)) : sum_v;
      if (arb_en_s && !grant_any_s && bus_io.req_valid[idx_v[ID_W-1:0]]) begin
        grant_any_s = 1'b1;
        grant_id_s  = idx_v[ID_W-1:0];
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // Grant strobe and operand steering; idle operands are driven to zero.
  always_comb begin
    req_ready_s = '0;
    din0_s      = '0;
    din1_s      = '0;
    if (grant_any_s) begin
      req_ready_s[grant_id_s] = 1'b1;
      din0_s = bus_io.req_a[grant_id_s*A_W +: A_W];
      din1_s = bus_io.req_b[grant_id_s*B_W +: B_W];
    end else begin
      req_ready_s = '0;
    end
  end

  // Result valid goes only to the requester whose tag sits at the pipe head.
  always_comb begin
    rsp_valid_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_s[i] = tag_v_q[LAST] & (head_id_s == ID_W'(i));
    end
  end

  // Tag pipe advances in lockstep with the multiplier clock enable.
  always_comb begin
    tag_v_d  = tag_v_q;
    tag_id_d = tag_id_q;
    if (ce_s) begin
      tag_v_d[0]  = grant_any_s;
      tag_id_d[0] = grant_id_s;
      for (int k = 1; k < MUL_LAT; k++) begin
        tag_v_d[k]  = tag_v_q[k-1];
        tag_id_d[k] = tag_id_q[k-1];
      end
    end else begin
      tag_v_d = tag_v_q;
    end
  end

  // Pointer moves just past the winner; in-flight count tracks grants minus retires.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    inflight_d = inflight_q;
    if (grant_any_s) begin
      rr_ptr_d = (grant_id_s == ID_W'(NUM_REQ - 1)) ? '0 : (grant_id_s + ID_W'(1));
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    case ({grant_any_s, retire_s})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01:   inflight_d = inflight_q - INF_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // State registers; reset discards every in-flight tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v_q    <= '0;
      rr_ptr_q   <= '0;
      inflight_q <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        tag_id_q[k] <= '0;
      end
    end else begin
      tag_v_q    <= tag_v_d;
      tag_id_q   <= tag_id_d;
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  assign bus_io.req_ready = req_ready_s;
  assign bus_io.rsp_valid = rsp_valid_s;
  assign bus_io.rsp_data  = rsp_data_s;
  assign bus_io.mul_ce    = ce_s;
  assign bus_io.mul_din0  = din0_s;
  assign bus_io.mul_din1  = din1_s;
  assign bus_io.inflight  = inflight_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: an external 3-stage multiplier model plus a scoreboard that
// predicts grants, result timing (counted in ce-enabled edges) and data from the block's rules.
module tb_mul_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int MUL_LAT = 3;
  localparam int A_W     = 10;
  localparam int B_W     = 11;
  localparam int P_W     = 20;

  logic clk;
  logic reset;

  mul_share_arbiter_if #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT), .A_W(A_W), .B_W(B_W), .P_W(P_W)) ifc ();

  mul_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(2), .MUL_LAT(MUL_LAT), .A_W(A_W), .B_W(B_W), .P_W(P_W))
    dut (.clk(clk), .reset(reset), .bus_io(ifc));

  // Shared multiplier: clock-enabled stages, no reset on the data path.
  logic [P_W-1:0] mp [MUL_LAT];
  always_ff @(posedge clk) begin
    if (ifc.mul_ce) begin
      mp[0] <= P_W'(32'(ifc.mul_din0) * 32'(ifc.mul_din1));
      for (int k = 1; k < MUL_LAT; k++) mp[k] <= mp[k-1];
    end
  end
  assign ifc.mul_dout = mp[MUL_LAT-1];

  always #5 clk = ~clk;

  typedef struct {
    int             id;
    logic [P_W-1:0] data;
    int             stamp;
  } item_t;

  item_t          sb[$];
  int             rr_m, ce_edges, errors, checks;
  logic           exp_vis, exp_ce;
  int             exp_g;
  logic [3:0]     exp_rr, exp_rv;
  logic [A_W-1:0] exp_d0;
  logic [B_W-1:0] exp_d1;

  task automatic rand_ops();
    ifc.req_a = 40'({$urandom(), $urandom()});
    ifc.req_b = 44'({$urandom(), $urandom()});
  endtask

  // Expected outputs for the current cycle; a result is visible once MUL_LAT-1 further ce edges have passed.
  task automatic predict();
    #1;
    exp_vis = (sb.size() > 0) && ((ce_edges - sb[0].stamp) >= MUL_LAT - 1);
    exp_rv  = 4'b0000;
    exp_ce  = 1'b1;
    if (exp_vis) begin
      exp_rv = 4'b0001 << sb[0].id;
      exp_ce = ifc.rsp_ready[sb[0].id];
    end
    exp_g = -1;
    if (exp_ce) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int c;
        c = (rr_m + k) % NUM_REQ;
        if (exp_g < 0 && ifc.req_valid[c]) exp_g = c;
      end
    end
    exp_rr = 4'b0000;
    exp_d0 = '0;
    exp_d1 = '0;
    if (exp_g >= 0) begin
      exp_rr = 4'b0001 << exp_g;
      exp_d0 = ifc.req_a[exp_g*A_W +: A_W];
      exp_d1 = ifc.req_b[exp_g*B_W +: B_W];
    end
  endtask

  // Apply the handshakes of the coming edge to the scoreboard, then move to the next falling edge.
  task automatic advance();
    logic [31:0] prod;
    if (exp_vis && ifc.rsp_ready[sb[0].id]) void'(sb.pop_front());
    if (exp_ce) ce_edges++;
    if (exp_g >= 0) begin
      prod = 32'(exp_d0) * 32'(exp_d1);
      sb.push_back('{exp_g, prod[P_W-1:0], ce_edges});
      rr_m = (exp_g + 1) % NUM_REQ;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ifc.req_valid = 4'($urandom_range(1, 15));
      #1;
      checks++;
      if ({ifc.req_ready, ifc.rsp_valid, ifc.mul_ce, ifc.inflight} !== {4'b0000, 4'b0000, 1'b1, 2'd0})
        begin errors++; $display("FAIL reset_state: rdy=%b rv=%b ce=%b infl=%0d, need 0000 0000 1 0",
                                 ifc.req_ready, ifc.rsp_valid, ifc.mul_ce, ifc.inflight); end
      @(negedge clk);
    end
    ifc.req_valid = 4'b0000;
    reset = 1'b1;
  endtask

  task automatic test_single();
    rand_ops();
    ifc.req_a[A_W +: A_W] = 10'd1023;
    ifc.req_b[B_W +: B_W] = 11'd2047;
    ifc.req_valid = 4'b0010;
    ifc.rsp_ready = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      predict();
      checks++; if ({ifc.req_ready, ifc.rsp_valid, ifc.mul_ce} !== {exp_rr, exp_rv, exp_ce}) begin errors++;
        $display("FAIL single_ctl c%0d: got %b/%b/%b need %b/%b/%b", c, ifc.req_ready, ifc.rsp_valid, ifc.mul_ce, exp_rr, exp_rv, exp_ce); end
      checks++; if ({ifc.mul_din0, ifc.mul_din1} !== {exp_d0, exp_d1}) begin errors++;
        $display("FAIL single_din c%0d: got %h/%h need %h/%h", c, ifc.mul_din0, ifc.mul_din1, exp_d0, exp_d1); end
      if (exp_vis) begin checks++; if (ifc.rsp_data !== sb[0].data) begin errors++;
        $display("FAIL single_data c%0d: got %h need %h", c, ifc.rsp_data, sb[0].data); end end
      if (c == 0) begin checks++; if (ifc.req_ready !== 4'b0010) begin errors++;
        $display("FAIL single_grant: got %b need 0010", ifc.req_ready); end end
      if (c == 3) begin checks++; if ({ifc.rsp_valid, ifc.rsp_data} !== {4'b0010, 20'hFF401}) begin errors++;
        $display("FAIL single_result: got %b %h need 0010 ff401", ifc.rsp_valid, ifc.rsp_data); end end
      advance();
      ifc.req_valid = 4'b0000;
    end
  endtask

  task automatic test_round_robin();
    ifc.rsp_ready = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      ifc.req_valid = (c < 12) ? 4'b1111 : 4'b0000;
      rand_ops();
      predict();
      checks++; if ({ifc.req_ready, ifc.rsp_valid, ifc.mul_ce} !== {exp_rr, exp_rv, exp_ce}) begin errors++;
        $display("FAIL rr_ctl c%0d: got %b/%b/%b need %b/%b/%b", c, ifc.req_ready, ifc.rsp_valid, ifc.mul_ce, exp_rr, exp_rv, exp_ce); end
      checks++; if (ifc.inflight !== 2'(sb.size())) begin errors++;
        $display("FAIL rr_inflight c%0d: got %0d need %0d", c, ifc.inflight, sb.size()); end
      if (exp_vis) begin checks++; if (ifc.rsp_data !== sb[0].data) begin errors++;
        $display("FAIL rr_data c%0d: got %h need %h", c, ifc.rsp_data, sb[0].data); end end
      if (c >= 3 && c < 15) begin checks++; if ($countones(ifc.rsp_valid) != 1) begin errors++;
        $display("FAIL rr_throughput c%0d: rsp_valid=%b need one-hot", c, ifc.rsp_valid); end end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int c, stalls, dut_stalls;
    c = 0; stalls = 0; dut_stalls = 0;
    ifc.rsp_ready = 4'b1011;
    while (stalls < 5 && c < 20) begin
      ifc.req_valid = (c == 0) ? 4'b0100 : ((c < 3) ? 4'b0011 : 4'b1011);
      rand_ops();
      predict();
      checks++; if ({ifc.req_ready, ifc.rsp_valid, ifc.mul_ce} !== {exp_rr, exp_rv, exp_ce}) begin errors++;
        $display("FAIL bp_ctl c%0d: got %b/%b/%b need %b/%b/%b", c, ifc.req_ready, ifc.rsp_valid, ifc.mul_ce, exp_rr, exp_rv, exp_ce); end
      if (exp_vis) begin checks++; if (ifc.rsp_data !== sb[0].data) begin errors++;
        $display("FAIL bp_data c%0d: got %h need %h", c, ifc.rsp_data, sb[0].data); end end
      if (ifc.mul_ce === 1'b0) dut_stalls++;
      if (!exp_ce) begin
        stalls++;
        checks++; if ({ifc.mul_ce, ifc.req_ready, ifc.rsp_valid} !== {1'b0, 4'b0000, 4'b0100}) begin errors++;
          $display("FAIL bp_hold c%0d: ce=%b rdy=%b rv=%b need 0 0000 0100", c, ifc.mul_ce, ifc.req_ready, ifc.rsp_valid); end
      end
      advance();
      c++;
    end
    checks++; if (dut_stalls != 5) begin errors++;
      $display("FAIL bp_stall_cycles: got %0d need 5", dut_stalls); end
    ifc.rsp_ready = 4'b1111;
    ifc.req_valid = 4'b0000;
    for (int d = 0; d < 6; d++) begin
      predict();
      checks++; if ({ifc.req_ready, ifc.rsp_valid, ifc.mul_ce} !== {exp_rr, exp_rv, exp_ce}) begin errors++;
        $display("FAIL bp_drain d%0d: got %b/%b/%b need %b/%b/%b", d, ifc.req_ready, ifc.rsp_valid, ifc.mul_ce, exp_rr, exp_rv, exp_ce); end
      if (exp_vis) begin checks++; if (ifc.rsp_data !== sb[0].data) begin errors++;
        $display("FAIL bp_drain_data d%0d: got %h need %h", d, ifc.rsp_data, sb[0].data); end end
      if (d == 5) begin checks++; if (ifc.inflight !== 2'd0) begin errors++;
        $display("FAIL bp_empty: inflight=%0d need 0", ifc.inflight); end end
      advance();
    end
  endtask

  task automatic test_sparse();
    ifc.rsp_ready = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      ifc.req_valid = (c % 2 == 0) ? 4'($urandom) : 4'b0000;
      rand_ops();
      predict();
      checks++; if ({ifc.req_ready, ifc.rsp_valid, ifc.mul_ce} !== {exp_rr, exp_rv, exp_ce}) begin errors++;
        $display("FAIL sparse_ctl c%0d: got %b/%b/%b need %b/%b/%b", c, ifc.req_ready, ifc.rsp_valid, ifc.mul_ce, exp_rr, exp_rv, exp_ce); end
      checks++; if (ifc.inflight !== 2'(sb.size())) begin errors++;
        $display("FAIL sparse_inflight c%0d: got %0d need %0d", c, ifc.inflight, sb.size()); end
      checks++; if ({ifc.mul_din0, ifc.mul_din1} !== {exp_d0, exp_d1}) begin errors++;
        $display("FAIL sparse_din c%0d: got %h/%h need %h/%h", c, ifc.mul_din0, ifc.mul_din1, exp_d0, exp_d1); end
      if (exp_vis) begin checks++; if (ifc.rsp_data !== sb[0].data) begin errors++;
        $display("FAIL sparse_data c%0d: got %h need %h", c, ifc.rsp_data, sb[0].data); end end
      advance();
    end
  endtask

  task automatic test_reset_midflight();
    ifc.rsp_ready = 4'b1111;
    ifc.req_valid = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      rand_ops();
      predict();
      checks++; if ({ifc.req_ready, ifc.rsp_valid, ifc.mul_ce} !== {exp_rr, exp_rv, exp_ce}) begin errors++;
        $display("FAIL midrst_ctl c%0d: got %b/%b/%b need %b/%b/%b", c, ifc.req_ready, ifc.rsp_valid, ifc.mul_ce, exp_rr, exp_rv, exp_ce); end
      advance();
    end
    predict();
    checks++; if (ifc.inflight !== 2'd3) begin errors++;
      $display("FAIL midrst_full: inflight=%0d need 3", ifc.inflight); end
    #1 reset = 1'b0;
    #1;
    checks++; if ({ifc.req_ready, ifc.rsp_valid, ifc.mul_ce, ifc.inflight} !== {4'b0000, 4'b0000, 1'b1, 2'd0}) begin errors++;
      $display("FAIL midrst_drop: rdy=%b rv=%b ce=%b infl=%0d need 0000 0000 1 0", ifc.req_ready, ifc.rsp_valid, ifc.mul_ce, ifc.inflight); end
    sb.delete();
    rr_m = 0;
    ce_edges = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 7; c++) begin
      ifc.req_valid = (c == 0) ? 4'b1111 : 4'b0000;
      rand_ops();
      predict();
      checks++; if ({ifc.req_ready, ifc.rsp_valid, ifc.mul_ce} !== {exp_rr, exp_rv, exp_ce}) begin errors++;
        $display("FAIL postrst_ctl c%0d: got %b/%b/%b need %b/%b/%b", c, ifc.req_ready, ifc.rsp_valid, ifc.mul_ce, exp_rr, exp_rv, exp_ce); end
      if (exp_vis) begin checks++; if (ifc.rsp_data !== sb[0].data) begin errors++;
        $display("FAIL postrst_data c%0d: got %h need %h", c, ifc.rsp_data, sb[0].data); end end
      if (c == 0) begin checks++; if (ifc.req_ready !== 4'b0001) begin errors++;
        $display("FAIL postrst_first_grant: got %b need 0001", ifc.req_ready); end end
      advance();
    end
  endtask

  task automatic test_retire_grant();
    for (int c = 0; c < 106; c++) begin
      ifc.req_valid = (c < 100) ? 4'($urandom) : 4'b0000;
      ifc.rsp_ready = (c < 100) ? (4'($urandom) | 4'($urandom)) : 4'b1111;
      rand_ops();
      predict();
      checks++; if ({ifc.req_ready, ifc.rsp_valid, ifc.mul_ce} !== {exp_rr, exp_rv, exp_ce}) begin errors++;
        $display("FAIL rnd_ctl c%0d: got %b/%b/%b need %b/%b/%b", c, ifc.req_ready, ifc.rsp_valid, ifc.mul_ce, exp_rr, exp_rv, exp_ce); end
      checks++; if (ifc.inflight !== 2'(sb.size())) begin errors++;
        $display("FAIL rnd_inflight c%0d: got %0d need %0d", c, ifc.inflight, sb.size()); end
      if (exp_vis) begin checks++; if (ifc.rsp_data !== sb[0].data) begin errors++;
        $display("FAIL rnd_data c%0d: got %h need %h", c, ifc.rsp_data, sb[0].data); end end
      if (c == 105) begin checks++; if (ifc.inflight !== 2'd0) begin errors++;
        $display("FAIL rnd_empty: inflight=%0d need 0", ifc.inflight); end end
      advance();
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    errors = 0;
    checks = 0;
    rr_m = 0;
    ce_edges = 0;
    ifc.req_valid = 4'b0000;
    ifc.rsp_ready = 4'b1111;
    rand_ops();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_reset_midflight();
    test_retire_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
